// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mycpu_pkg
// Brief    : Shared pipeline defaults, writeback lane record and trace FSM states
// Revision : 1.0
// ============================================================================
package mycpu_pkg;

  localparam int c_lanes       = 2;
  localparam int c_xlen        = 32;
  localparam int c_rf_aw       = 5;
  localparam int c_csr_iw      = 14;
  localparam int c_ecode_w     = 6;
  localparam int c_esubcode_w  = 3;
  localparam int c_excp_num_w  = c_esubcode_w + c_ecode_w;

  // Field widths follow the package defaults; width parameters must match them.
  typedef struct packed {
    logic [c_xlen-1:0]       pc;
    logic                    gr_we;
    logic [c_rf_aw-1:0]      dest;
    logic [c_xlen-1:0]       result;
    logic                    excp;
    logic [c_excp_num_w-1:0] excp_num;
    logic                    ertn;
    logic                    csr_we;
    logic [c_csr_iw-1:0]     csr_idx;
    logic [c_xlen-1:0]       csr_wdata;
  } lane_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_commit_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage_if
// Brief    : Memory-stage to writeback-stage issue-group handshake bundle
// Revision : 1.0
// ============================================================================
interface wb_commit_stage_if
  import mycpu_pkg::*;
#(
  parameter int LANES   = c_lanes,
  parameter int XLEN    = c_xlen,
  parameter int RF_AW   = c_rf_aw,
  parameter int CSR_IW  = c_csr_iw,
  parameter int ECODE_W = c_excp_num_w
);
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [LANES-1:0]           ms_lane_valid;
  logic [LANES*XLEN-1:0]      ms_pc;
  logic [LANES-1:0]           ms_gr_we;
  logic [LANES*RF_AW-1:0]     ms_dest;
  logic [LANES*XLEN-1:0]      ms_result;
  logic [LANES-1:0]           ms_excp;
  logic [LANES*ECODE_W-1:0]   ms_excp_num;
  logic [LANES-1:0]           ms_ertn;
  logic [LANES-1:0]           ms_csr_we;
  logic [LANES*CSR_IW-1:0]    ms_csr_idx;
  logic [LANES*XLEN-1:0]      ms_csr_wdata;

  modport master (
    input  ws_allowin,
    output ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
           ms_excp, ms_excp_num, ms_ertn, ms_csr_we, ms_csr_idx, ms_csr_wdata
  );

  modport slave (
    output ws_allowin,
    input  ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
           ms_excp, ms_excp_num, ms_ertn, ms_csr_we, ms_csr_idx, ms_csr_wdata
  );
endinterface
`default_nettype wire

// File: rtl/wb_commit_mask.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_mask
// Brief    : Per-group exception/ertn priority, commit mask and GR write dedup
// Revision : 1.0
// ============================================================================
module wb_commit_mask #(
  parameter int LANES = 2,
  parameter int RF_AW = 5,
  parameter int K_W   = 1,
  parameter int CNT_W = 2
) (
  input  wire logic [LANES-1:0]       lane_valid,
  input  wire logic [LANES-1:0]       excp,
  input  wire logic [LANES-1:0]       ertn,
  input  wire logic [LANES-1:0]       gr_we,
  input  wire logic [LANES*RF_AW-1:0] dest,
  output logic      [LANES-1:0]       commit,
  output logic      [LANES-1:0]       gr_elig,
  output logic      [LANES-1:0]       rf_mask,
  output logic                        found,
  output logic                        k_excp,
  output logic      [K_W-1:0]         k_idx,
  output logic      [CNT_W-1:0]       n_commit
);

  always_comb begin
    found = 1'b0;
    k_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!found && lane_valid[i] && (excp[i] || ertn[i])) begin
        found = 1'b1;
        k_idx = K_W'(i);
      end
    end
  end

  assign k_excp = found && excp[k_idx];

  // Lane k stays committed only when it is a pure ertn; it still never writes GR.
  always_comb begin
    commit   = '0;
    gr_elig  = '0;
    n_commit = '0;
    for (int i = 0; i < LANES; i++) begin
      commit[i]  = lane_valid[i] &&
                   (!found || (K_W'(i) < k_idx) || ((K_W'(i) == k_idx) && !excp[i]));
      gr_elig[i] = commit[i] && gr_we[i] && !(found && (K_W'(i) == k_idx));
      n_commit   = n_commit + CNT_W'(commit[i]);
    end
  end

  always_comb begin
    rf_mask = gr_elig;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (gr_elig[j] && (dest[j*RF_AW +: RF_AW] == dest[i*RF_AW +: RF_AW]) &&
            (dest[i*RF_AW +: RF_AW] != '0)) begin
          rf_mask[i] = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage
// Brief    : Multi-lane writeback/commit stage with serialised trace port
// Revision : 1.0
// ============================================================================
module wb_commit_stage
  import mycpu_pkg::*;
#(
  parameter int LANES   = c_lanes,
  parameter int XLEN    = c_xlen,
  parameter int RF_AW   = c_rf_aw,
  parameter int CSR_IW  = c_csr_iw,
  parameter int ECODE_W = c_excp_num_w
) (
  input  wire logic               clk,
  input  wire logic               reset,
  wb_commit_stage_if.slave        ms,
  output logic [LANES-1:0]        rf_we,
  output logic [LANES*RF_AW-1:0]  rf_waddr,
  output logic [LANES*XLEN-1:0]   rf_wdata,
  output logic [LANES-1:0]        ws_fwd_valid,
  output logic                    csr_we,
  output logic [CSR_IW-1:0]       csr_idx,
  output logic [XLEN-1:0]         csr_wdata,
  output logic                    excp_flush,
  output logic                    ertn_flush,
  output logic [XLEN-1:0]         excp_pc,
  output logic [ECODE_W-1:0]      excp_num,
  output logic [XLEN-1:0]         debug_wb_pc,
  output logic [3:0]              debug_wb_rf_we,
  output logic [RF_AW-1:0]        debug_wb_rf_wnum,
  output logic [XLEN-1:0]         debug_wb_rf_wdata
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam int K_W   = (LANES > 1) ? $clog2(LANES) : 1;

  lane_t              r_lane [LANES];
  logic [LANES-1:0]   r_lane_valid;
  logic               r_ws_valid;
  logic               r_first;
  logic [CNT_W-1:0]   r_cnt;
  wb_state_e          r_state;
  wb_state_e          w_state_nxt;

  logic [LANES-1:0]       w_excp, w_ertn, w_gr_we;
  logic [LANES*RF_AW-1:0] w_dest;
  logic [LANES-1:0]       w_commit, w_elig, w_rf_mask;
  logic                   w_found, w_k_excp;
  logic [K_W-1:0]         w_k;
  logic [CNT_W-1:0]       w_n_commit;
  logic [CNT_W-1:0]       w_seen;
  logic                   w_last, w_allowin, w_capture;

  always_comb begin
    w_excp  = '0;
    w_ertn  = '0;
    w_gr_we = '0;
    w_dest  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_excp[i]                 = r_lane[i].excp;
      w_ertn[i]                 = r_lane[i].ertn;
      w_gr_we[i]                = r_lane[i].gr_we;
      w_dest[i*RF_AW +: RF_AW]  = r_lane[i].dest;
    end
  end

  wb_commit_mask #(
    .LANES (LANES),
    .RF_AW (RF_AW),
    .K_W   (K_W),
    .CNT_W (CNT_W)
  ) u_mask (
    .lane_valid (r_lane_valid),
    .excp       (w_excp),
    .ertn       (w_ertn),
    .gr_we      (w_gr_we),
    .dest       (w_dest),
    .commit     (w_commit),
    .gr_elig    (w_elig),
    .rf_mask    (w_rf_mask),
    .found      (w_found),
    .k_excp     (w_k_excp),
    .k_idx      (w_k),
    .n_commit   (w_n_commit)
  );

  // A group with nothing committed still occupies one trace cycle.
  assign w_last    = (w_n_commit == '0) || (r_cnt == (w_n_commit - CNT_W'(1)));
  assign w_allowin = !reset && (!r_ws_valid || ((r_state == ST_DRAIN) && w_last));
  assign w_capture = w_allowin && ms.ms_to_ws_valid;
  assign ms.ws_allowin = w_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_capture) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last && !w_capture) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ws_valid   <= 1'b0;
      r_first      <= 1'b0;
      r_cnt        <= '0;
      r_lane_valid <= '0;
      for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
    end else begin
      r_first <= w_capture;
      if (w_capture) begin
        r_ws_valid   <= 1'b1;
        r_cnt        <= '0;
        r_lane_valid <= ms.ms_lane_valid;
        for (int i = 0; i < LANES; i++) begin
          r_lane[i].pc        <= ms.ms_pc[i*XLEN +: XLEN];
          r_lane[i].gr_we     <= ms.ms_gr_we[i];
          r_lane[i].dest      <= ms.ms_dest[i*RF_AW +: RF_AW];
          r_lane[i].result    <= ms.ms_result[i*XLEN +: XLEN];
          r_lane[i].excp      <= ms.ms_excp[i];
          r_lane[i].excp_num  <= ms.ms_excp_num[i*ECODE_W +: ECODE_W];
          r_lane[i].ertn      <= ms.ms_ertn[i];
          r_lane[i].csr_we    <= ms.ms_csr_we[i];
          r_lane[i].csr_idx   <= ms.ms_csr_idx[i*CSR_IW +: CSR_IW];
          r_lane[i].csr_wdata <= ms.ms_csr_wdata[i*XLEN +: XLEN];
        end
      end else if (r_state == ST_DRAIN) begin
        if (w_last) r_ws_valid <= 1'b0;
        else        r_cnt      <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rf_we             = '0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    ws_fwd_valid      = '0;
    csr_we            = 1'b0;
    csr_idx           = '0;
    csr_wdata         = '0;
    excp_flush        = 1'b0;
    ertn_flush        = 1'b0;
    excp_pc           = '0;
    excp_num          = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    w_seen            = '0;
    for (int i = 0; i < LANES; i++) begin
      rf_waddr[i*RF_AW +: RF_AW] = r_lane[i].dest;
      rf_wdata[i*XLEN +: XLEN]   = r_lane[i].result;
    end
    if (r_ws_valid) begin
      ws_fwd_valid = w_rf_mask;
      if (r_first) begin
        rf_we = w_rf_mask;
        if (w_found && w_k_excp) begin
          excp_flush = 1'b1;
          excp_pc    = r_lane[w_k].pc;
          excp_num   = r_lane[w_k].excp_num;
        end
        ertn_flush = w_found && !w_k_excp;
        for (int i = 0; i < LANES; i++) begin
          if (r_lane[i].csr_we && w_commit[i]) begin
            csr_we    = 1'b1;
            csr_idx   = r_lane[i].csr_idx;
            csr_wdata = r_lane[i].csr_wdata;
          end
        end
      end
    end
    // r_cnt is the rank among committed lanes of the one presented this cycle.
    if (r_state == ST_DRAIN) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_commit[i]) begin
          if (w_seen == r_cnt) begin
            debug_wb_pc       = r_lane[i].pc;
            debug_wb_rf_we    = {4{w_elig[i]}};
            debug_wb_rf_wnum  = r_lane[i].dest;
            debug_wb_rf_wdata = r_lane[i].result;
          end
          w_seen = w_seen + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_stage
// Brief    : Directed + randomized bench for wb_commit_stage with a queue model
// Revision : 1.0
// ============================================================================
module tb_wb_commit_stage;

  localparam int L  = 2;
  localparam int XW = 32;
  localparam int AW = 5;
  localparam int IW = 14;
  localparam int EW = 9;

  typedef struct packed {
    logic [L-1:0]         lv;
    logic [L-1:0][XW-1:0] pc;
    logic [L-1:0]         gr_we;
    logic [L-1:0][AW-1:0] dest;
    logic [L-1:0][XW-1:0] res;
    logic [L-1:0]         excp;
    logic [L-1:0][EW-1:0] en;
    logic [L-1:0]         ertn;
    logic [L-1:0]         csr_we;
    logic [L-1:0][IW-1:0] cidx;
    logic [L-1:0][XW-1:0] cdata;
  } grp_t;

  typedef struct packed {
    logic [XW-1:0] pc;
    logic          we;
    logic [AW-1:0] dest;
    logic [XW-1:0] data;
  } tr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [L-1:0]     rf_we, ws_fwd_valid;
  logic [L*AW-1:0]  rf_waddr;
  logic [L*XW-1:0]  rf_wdata;
  logic             csr_we, excp_flush, ertn_flush;
  logic [IW-1:0]    csr_idx;
  logic [XW-1:0]    csr_wdata, excp_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [EW-1:0]    excp_num;
  logic [3:0]       debug_wb_rf_we;
  logic [AW-1:0]    debug_wb_rf_wnum;

  wb_commit_stage_if #(.LANES(L), .XLEN(XW), .RF_AW(AW), .CSR_IW(IW), .ECODE_W(EW)) u_if ();

  wb_commit_stage #(.LANES(L), .XLEN(XW), .RF_AW(AW), .CSR_IW(IW), .ECODE_W(EW)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .ms                (u_if),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .csr_we            (csr_we),
    .csr_idx           (csr_idx),
    .csr_wdata         (csr_wdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush),
    .excp_pc           (excp_pc),
    .excp_num          (excp_num),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: resident group plus the queue of trace entries still owed.
  bit            m_valid, m_first, m_is_excp, m_is_ertn, m_csr_v;
  int            m_k;
  grp_t          m_g;
  logic [L-1:0]  m_mask;
  logic [IW-1:0] m_cidx;
  logic [XW-1:0] m_cdata;
  tr_t           tq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit lane_commits(input grp_t g, input int kk, input int i);
    return g.lv[i] && ((kk < 0) || (i < kk) || ((i == kk) && !g.excp[i]));
  endfunction

  task automatic model_load(input grp_t g);
    bit [31:0] claimed;
    tr_t e;
    m_g = g; m_valid = 1; m_first = 1; m_mask = '0; m_csr_v = 0;
    m_cidx = '0; m_cdata = '0; m_k = -1; claimed = '0;
    tq.delete();
    for (int i = 0; i < L; i++)
      if (m_k < 0 && g.lv[i] && (g.excp[i] || g.ertn[i])) m_k = i;
    m_is_excp = (m_k >= 0) && g.excp[m_k];
    m_is_ertn = (m_k >= 0) && !g.excp[m_k];
    // Youngest writer of each nonzero register wins.
    for (int i = L - 1; i >= 0; i--) begin
      if (lane_commits(g, m_k, i) && g.gr_we[i] && i != m_k) begin
        if (g.dest[i] == 0 || !claimed[g.dest[i]]) m_mask[i] = 1'b1;
        claimed[g.dest[i]] = 1'b1;
      end
    end
    for (int i = 0; i < L; i++) begin
      if (lane_commits(g, m_k, i)) begin
        e.pc = g.pc[i]; e.we = g.gr_we[i] && (i != m_k);
        e.dest = g.dest[i]; e.data = g.res[i];
        tq.push_back(e);
        if (g.csr_we[i]) begin m_csr_v = 1; m_cidx = g.cidx[i]; m_cdata = g.cdata[i]; end
      end
    end
  endtask

  task automatic check_outputs();
    logic [L-1:0] e_we;
    tr_t e_tr;
    chk("allowin", u_if.ws_allowin, (!m_valid || tq.size() <= 1));
    e_we = (m_valid && m_first) ? m_mask : '0;
    chk("rf_we", rf_we, e_we);
    for (int i = 0; i < L; i++) begin
      if (e_we[i]) begin
        chk("rf_waddr", rf_waddr[i*AW +: AW], m_g.dest[i]);
        chk("rf_wdata", rf_wdata[i*XW +: XW], m_g.res[i]);
      end
    end
    chk("fwd_valid", ws_fwd_valid, m_valid ? m_mask : '0);
    chk("csr_we", csr_we, m_valid && m_first && m_csr_v);
    if (m_valid && m_first && m_csr_v) begin
      chk("csr_idx", csr_idx, m_cidx);
      chk("csr_wdata", csr_wdata, m_cdata);
    end
    chk("excp_flush", excp_flush, m_valid && m_first && m_is_excp);
    chk("ertn_flush", ertn_flush, m_valid && m_first && m_is_ertn);
    if (m_valid && m_first && m_is_excp) begin
      chk("excp_pc", excp_pc, m_g.pc[m_k]);
      chk("excp_num", excp_num, m_g.en[m_k]);
    end
    e_tr = (m_valid && tq.size() > 0) ? tq[0] : '0;
    chk("dbg_pc", debug_wb_pc, e_tr.pc);
    chk("dbg_we", debug_wb_rf_we, {4{e_tr.we}});
    chk("dbg_wnum", debug_wb_rf_wnum, e_tr.dest);
    chk("dbg_wdata", debug_wb_rf_wdata, e_tr.data);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_allowin"}, u_if.ws_allowin, 0);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_fwd"}, ws_fwd_valid, 0);
    chk({tag, "_csr_we"}, csr_we, 0);
    chk({tag, "_flush"}, {excp_flush, ertn_flush}, 0);
    chk({tag, "_dbg_pc"}, debug_wb_pc, 0);
    chk({tag, "_dbg_we"}, debug_wb_rf_we, 0);
    chk({tag, "_dbg_wdata"}, debug_wb_rf_wdata, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
  endtask

  task automatic step(input bit v, input grp_t g, output bit acc);
    @(negedge clk);
    check_outputs();
    u_if.ms_to_ws_valid = v;
    u_if.ms_lane_valid  = g.lv;
    u_if.ms_pc          = g.pc;
    u_if.ms_gr_we       = g.gr_we;
    u_if.ms_dest        = g.dest;
    u_if.ms_result      = g.res;
    u_if.ms_excp        = g.excp;
    u_if.ms_excp_num    = g.en;
    u_if.ms_ertn        = g.ertn;
    u_if.ms_csr_we      = g.csr_we;
    u_if.ms_csr_idx     = g.cidx;
    u_if.ms_csr_wdata   = g.cdata;
    acc = v && (!m_valid || tq.size() <= 1);
    if (acc) model_load(g);
    else begin
      m_first = 0;
      if (m_valid) begin
        if (tq.size() <= 1) m_valid = 0;
        if (tq.size() > 0) void'(tq.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, acc);
  endtask

  function automatic grp_t rand_grp();
    grp_t g;
    int cl;
    g = '0;
    for (int i = 0; i < L; i++) begin
      g.lv[i]    = ($urandom % 8) != 0;
      g.pc[i]    = 32'h1c00_0000 + ($urandom % 1024) * 4;
      g.dest[i]  = 5'($urandom % 8);
      g.res[i]   = $urandom;
      g.excp[i]  = ($urandom % 6) == 0;
      g.ertn[i]  = ($urandom % 6) == 0;
      g.gr_we[i] = !g.ertn[i] && (($urandom % 4) != 0);
      g.en[i]    = 9'($urandom);
    end
    cl = int'($urandom % 4);
    if (cl < L) begin
      g.csr_we[cl] = 1'b1;
      g.cidx[cl]   = 14'($urandom);
      g.cdata[cl]  = $urandom;
    end
    return g;
  endfunction

  function automatic grp_t clean2(input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [4:0] r0, input logic [4:0] r1);
    grp_t g;
    g = '0;
    g.lv = 2'b11; g.gr_we = 2'b11;
    g.pc[0] = 32'h1c00_0000; g.pc[1] = 32'h1c00_0004;
    g.dest[0] = r0; g.dest[1] = r1; g.res[0] = d0; g.res[1] = d1;
    return g;
  endfunction

  initial begin
    grp_t g, cur;
    bit acc;
    reset = 1'b1;
    u_if.ms_to_ws_valid = 1'b0;
    u_if.ms_lane_valid = '0; u_if.ms_pc = '0; u_if.ms_gr_we = '0; u_if.ms_dest = '0;
    u_if.ms_result = '0; u_if.ms_excp = '0; u_if.ms_excp_num = '0; u_if.ms_ertn = '0;
    u_if.ms_csr_we = '0; u_if.ms_csr_idx = '0; u_if.ms_csr_wdata = '0;
    m_valid = 0; m_first = 0; tq.delete();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Two clean lanes
    step(1'b1, clean2(32'hA, 32'hB, 5'd4, 5'd5), acc); idle(3);
    // Lane 0 exception squashes lane 1
    g = clean2(32'h1, 32'h2, 5'd3, 5'd6); g.excp[0] = 1'b1; g.en[0] = 9'h0B;
    step(1'b1, g, acc); idle(2);
    // Lane 0 ertn, lane 1 exception
    g = clean2(32'h1, 32'h2, 5'd3, 5'd6); g.gr_we[0] = 1'b0; g.ertn[0] = 1'b1; g.excp[1] = 1'b1;
    step(1'b1, g, acc); idle(2);
    // Same destination in both lanes
    step(1'b1, clean2(32'h11, 32'h22, 5'd7, 5'd7), acc); idle(3);
    // CSR write squashed by older exception, then committed
    g = clean2(32'h1, 32'h2, 5'd3, 5'd6); g.csr_we[1] = 1'b1; g.cidx[1] = 14'h6;
    g.cdata[1] = 32'h5; g.excp[0] = 1'b1;
    step(1'b1, g, acc); idle(2);
    g.excp[0] = 1'b0;
    step(1'b1, g, acc); idle(3);

    // Back-to-back with valid held high
    cur = rand_grp();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, cur, acc);
      if (acc) cur = rand_grp();
    end
    idle(3);

    // Random traffic
    cur = rand_grp();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, cur, acc);
      if (acc) cur = rand_grp();
    end
    idle(3);

    // Reset in the middle of a two-lane drain
    step(1'b1, clean2(32'hC, 32'hD, 5'd8, 5'd9), acc);
    step(1'b0, '0, acc);
    #1 reset = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    m_valid = 0; m_first = 0; tq.delete();
    idle(2);
    step(1'b1, clean2(32'hE, 32'hF, 5'd1, 5'd2), acc); idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
